// File: rtl/ctrl_link_pkg.sv
// ============================================================================
// Module   : ctrl_link_pkg
// Desc     : Shared constants, receive-state enum and bit indices for the
//            control-link slave (options: CTRL_LINK_CHECKSUM_EN)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package ctrl_link_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } rx_state_t;

  localparam int HDR_STROBE  = 0;
  localparam int HDR_WRITE   = 1;
  localparam int HDR_TAG_LSB = 4;

  localparam int ST_ACK     = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_BUSY    = 2;

endpackage

`default_nettype wire

// File: rtl/ctrl_link_tx_framer.sv
// ============================================================================
// Module   : ctrl_link_tx_framer
// Desc     : Back-to-back response frame generator with per-frame snapshot
//            (options: CTRL_LINK_CHECKSUM_EN appends an XOR checksum byte)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module ctrl_link_tx_framer
  import ctrl_link_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                    byte_clk,
  input  logic                    reset,
  input  logic [7:0]              status,
  input  logic [8*DATA_BYTES-1:0] resp_data,
  output logic [7:0]              tx_byte,
  output logic                    tx_k
);

`ifdef CTRL_LINK_CHECKSUM_EN
  localparam int FRAME_LEN = DATA_BYTES + 3;
`else
  localparam int FRAME_LEN = DATA_BYTES + 2;
`endif
  localparam int PW = $clog2(FRAME_LEN);

  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           w_ptr_next;
  logic [7:0]              r_status;
  logic [8*DATA_BYTES-1:0] r_resp;
  logic [7:0]              w_chk;
  logic [7:0]              w_byte_next;
  logic                    w_k_next;

  always_comb begin
    w_ptr_next = (r_ptr == PW'(FRAME_LEN - 1)) ? '0 : r_ptr + 1'b1;
    w_chk = r_status;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_chk = w_chk ^ r_resp[8*i +: 8];
    end
  end

  // r_ptr names the byte currently on tx_byte; the next one is chosen here.
  always_comb begin
    w_byte_next = K_COMMA;
    w_k_next    = 1'b1;
    if (w_ptr_next == PW'(1)) begin
      w_byte_next = r_status;
      w_k_next    = 1'b0;
    end else if (w_ptr_next != '0) begin
      w_byte_next = w_chk;
      w_k_next    = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (w_ptr_next == PW'(i + 2)) begin
          w_byte_next = r_resp[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      r_ptr    <= '0;
      tx_byte  <= K_COMMA;
      tx_k     <= 1'b1;
      r_status <= '0;
      r_resp   <= '0;
    end else begin
      r_ptr   <= w_ptr_next;
      tx_byte <= w_byte_next;
      tx_k    <= w_k_next;
      if (w_ptr_next == '0) begin
        r_status <= status;
        r_resp   <= resp_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_link_slave_param.sv
// ============================================================================
// Module   : ctrl_link_slave_param
// Desc     : Control-link slave: request frame parser, bus strobe/ack with
//            timeout, tag duplicate suppression, error counting, response tx
//            (options: CTRL_LINK_CHECKSUM_EN)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module ctrl_link_slave_param
  import ctrl_link_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    byte_clk,
  input  logic                    reset,
  input  logic                    link_ok,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_k,
  output logic [7:0]              tx_byte,
  output logic                    tx_k,
  output logic [8*ADDR_BYTES-1:0] address,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    request_is_write,
  output logic                    strobe,
  input  logic                    ack,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    frame_err,
  output logic [15:0]             err_count
);

  rx_state_t               r_state;
  logic [2:0]              r_cnt;
  logic                    r_hdr_strobe;
  logic                    r_hdr_write;
  logic [3:0]              r_hdr_tag;
  logic [8*ADDR_BYTES-1:0] r_addr_sh;
  logic [8*DATA_BYTES-1:0] r_data_sh;
  logic [3:0]              r_last_tag;
  logic                    r_tag_valid;
  logic                    r_st_ack;
  logic                    r_st_timeout;
  logic                    r_st_busy;
  logic [8*DATA_BYTES-1:0] r_resp;
  logic [15:0]             r_tmo_cnt;
`ifdef CTRL_LINK_CHECKSUM_EN
  logic [7:0]              r_chk;
`endif

  logic                    w_is_comma;
  logic                    w_bad_k;
  logic                    w_last_addr;
  logic                    w_last_data;
  logic                    w_accept;
  logic                    w_chk_err;
  logic                    w_err;
  logic                    w_exec;
  logic                    w_busy;
  logic [8*DATA_BYTES-1:0] w_frame_data;
  logic [7:0]              w_status;

  always_comb begin
    w_is_comma   = rx_k && (rx_byte == K_COMMA);
    w_bad_k      = rx_k && !w_is_comma;
    w_last_addr  = (r_cnt == 3'(ADDR_BYTES - 1));
    w_last_data  = (r_cnt == 3'(DATA_BYTES - 1));
    w_frame_data = r_data_sh;
`ifdef CTRL_LINK_CHECKSUM_EN
    w_chk_err = !rx_k && (r_state == CHK) && (rx_byte != r_chk);
    w_accept  = !rx_k && (r_state == CHK) && (rx_byte == r_chk);
`else
    // Without a checksum the frame completes on the byte still on rx_byte.
    w_chk_err = 1'b0;
    w_accept  = !rx_k && (r_state == DATA) && w_last_data;
    w_frame_data[8*(DATA_BYTES-1) +: 8] = rx_byte;
`endif
    w_err  = link_ok && ((w_is_comma && (r_state != HUNT)) || w_bad_k || w_chk_err);
    w_exec = link_ok && w_accept && r_hdr_strobe && !strobe &&
             !(r_tag_valid && (r_hdr_tag == r_last_tag));
    w_busy = link_ok && w_accept && r_hdr_strobe && strobe;

    w_status          = '0;
    w_status[7:4]     = r_last_tag;
    w_status[ST_ACK]     = r_st_ack;
    w_status[ST_TIMEOUT] = r_st_timeout;
    w_status[ST_BUSY]    = r_st_busy;
  end

  always_ff @(posedge byte_clk) begin
    if (reset) begin
      r_state          <= HUNT;
      r_cnt            <= '0;
      r_hdr_strobe     <= 1'b0;
      r_hdr_write      <= 1'b0;
      r_hdr_tag        <= '0;
      r_addr_sh        <= '0;
      r_data_sh        <= '0;
      r_last_tag       <= '0;
      r_tag_valid      <= 1'b0;
      r_st_ack         <= 1'b0;
      r_st_timeout     <= 1'b0;
      r_st_busy        <= 1'b0;
      r_resp           <= '0;
      r_tmo_cnt        <= '0;
      strobe           <= 1'b0;
      address          <= '0;
      data_out         <= '0;
      request_is_write <= 1'b0;
      frame_err        <= 1'b0;
      err_count        <= '0;
`ifdef CTRL_LINK_CHECKSUM_EN
      r_chk            <= '0;
`endif
    end else begin
      frame_err <= w_err;
      if (w_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end

      // Ack is tested before the timeout so a coincident ack wins.
      if (strobe) begin
        if (ack) begin
          strobe       <= 1'b0;
          r_resp       <= data_in;
          r_st_ack     <= 1'b1;
          r_st_timeout <= 1'b0;
        end else if (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          strobe       <= 1'b0;
          r_resp       <= '0;
          r_st_ack     <= 1'b0;
          r_st_timeout <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
      end

      if (w_busy) begin
        r_st_busy <= 1'b1;
      end
      if (w_exec) begin
        strobe           <= 1'b1;
        address          <= r_addr_sh;
        data_out         <= w_frame_data;
        request_is_write <= r_hdr_write;
        r_last_tag       <= r_hdr_tag;
        r_tag_valid      <= 1'b1;
        r_tmo_cnt        <= '0;
        r_st_ack         <= 1'b0;
        r_st_timeout     <= 1'b0;
        r_st_busy        <= 1'b0;
      end

      if (!link_ok) begin
        r_state          <= HUNT;
        strobe           <= 1'b0;
        address          <= '0;
        data_out         <= '0;
        request_is_write <= 1'b0;
      end else if (w_is_comma) begin
        r_state <= HDR;
      end else if (rx_k) begin
        r_state <= HUNT;
      end else begin
        case (r_state)
          HUNT: r_state <= HUNT;
          HDR: begin
            r_hdr_strobe <= rx_byte[HDR_STROBE];
            r_hdr_write  <= rx_byte[HDR_WRITE];
            r_hdr_tag    <= rx_byte[HDR_TAG_LSB +: 4];
            r_cnt        <= '0;
            r_state      <= ADDR;
`ifdef CTRL_LINK_CHECKSUM_EN
            r_chk        <= rx_byte;
`endif
          end
          ADDR: begin
            for (int i = 0; i < ADDR_BYTES; i++) begin
              if (r_cnt == 3'(i)) r_addr_sh[8*i +: 8] <= rx_byte;
            end
            r_cnt   <= w_last_addr ? '0 : r_cnt + 3'd1;
            r_state <= w_last_addr ? DATA : ADDR;
`ifdef CTRL_LINK_CHECKSUM_EN
            r_chk   <= r_chk ^ rx_byte;
`endif
          end
          DATA: begin
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (r_cnt == 3'(i)) r_data_sh[8*i +: 8] <= rx_byte;
            end
            r_cnt <= w_last_data ? '0 : r_cnt + 3'd1;
`ifdef CTRL_LINK_CHECKSUM_EN
            r_chk   <= r_chk ^ rx_byte;
            r_state <= w_last_data ? CHK : DATA;
`else
            r_state <= w_last_data ? HUNT : DATA;
`endif
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  ctrl_link_tx_framer #(
    .DATA_BYTES (DATA_BYTES)
  ) u_tx_framer (
    .byte_clk  (byte_clk),
    .reset     (reset),
    .status    (w_status),
    .resp_data (r_resp),
    .tx_byte   (tx_byte),
    .tx_k      (tx_k)
  );

endmodule

`default_nettype wire
